ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 120 ++++++++++++
 tb/tb_ifu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding request to instruction memory, a
// single-entry hold buffer toward decode, and predecoder-driven next-PC.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [31:0] req_addr_o,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_data_i,
    output logic [31:0] bjp_inst_o,
    output logic [31:0] bjp_pc_o,
    input  logic [31:0] bjp_pred_pc_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [31:0] out_pc_o,
    output logic [31:0] fetch_cnt_o
);
    localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state, state_nx;
    logic        drop, drop_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] out_inst, inst_nx;
    logic [31:0] out_pc, opc_nx;
    logic [31:0] cnt, cnt_nx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            drop     <= 1'b0;
            pc       <= RESET_PC & ALIGN;
            out_inst <= '0;
            out_pc   <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nx;
            drop     <= drop_nx;
            pc       <= pc_nx;
            out_inst <= inst_nx;
            out_pc   <= opc_nx;
            cnt      <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        drop_nx  = drop;
        pc_nx    = pc;
        inst_nx  = out_inst;
        opc_nx   = out_pc;
        cnt_nx   = cnt;
        case (state)
            IDLE: state_nx = REQ;
            REQ: begin
                // A redirect racing an accepted request still owes us one
                // response, which must be swallowed.
                if (redirect_valid_i) begin
                    pc_nx = redirect_pc_i & ALIGN;
                    if (req_ready_i) begin
                        drop_nx  = 1'b1;
                        state_nx = WAIT;
                    end
                end else if (req_ready_i) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid_i) begin
                    pc_nx = redirect_pc_i & ALIGN;
                    if (resp_valid_i) begin
                        drop_nx  = 1'b0;
                        state_nx = REQ;
                    end else begin
                        drop_nx = 1'b1;
                    end
                end else if (resp_valid_i) begin
                    if (drop) begin
                        drop_nx  = 1'b0;
                        state_nx = REQ;
                    end else begin
                        inst_nx  = resp_data_i;
                        opc_nx   = pc;
                        pc_nx    = bjp_pred_pc_i & ALIGN;
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready_i) cnt_nx = cnt + 32'd1;
                if (redirect_valid_i) begin
                    pc_nx    = redirect_pc_i & ALIGN;
                    state_nx = REQ;
                end else if (out_ready_i) begin
                    state_nx = REQ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The predecoder sees the live response while waiting so the next PC is
    // ready in the same cycle the word is captured.
    assign bjp_inst_o  = (state == WAIT) ? resp_data_i : out_inst;
    assign bjp_pc_o    = (state == WAIT) ? pc : out_pc;

    assign req_valid_o = (state == REQ);
    assign req_addr_o  = pc;
    assign out_valid_o = (state == HOLD);
    assign out_inst_o  = out_inst;
    assign out_pc_o    = out_pc;
    assign fetch_cnt_o = cnt;
endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios then randomized traffic, checked against a
// program-flow model (expected next PC, delivered count, memory contents).
module tb_ifu;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid_o, req_ready_i;
    logic [31:0] req_addr_o;
    logic        resp_valid_i;
    logic [31:0] resp_data_i;
    logic [31:0] bjp_inst_o, bjp_pc_o, bjp_pred_pc_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] out_inst_o, out_pc_o, fetch_cnt_o;

    ifu #(.RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
        .bjp_inst_o(bjp_inst_o), .bjp_pc_o(bjp_pc_o), .bjp_pred_pc_i(bjp_pred_pc_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_inst_o(out_inst_o), .out_pc_o(out_pc_o), .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    // stimulus knobs for the next cycle
    logic        rst_r = 1'b1, rdy_r = 1'b1, ordy_r = 1'b1, redir_r = 1'b0, spur_r = 1'b0;
    logic [31:0] rpc_r = '0;
    int          lat_r = 0;

    // program image and model state
    int          mode = 0;
    logic [31:0] jal_addr = '0;
    logic        model_ok = 1'b0, after_rst = 1'b0;
    logic [31:0] exp_pc = RPC;
    logic [31:0] exp_cnt = '0;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_wait = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (mode == 0) return 32'h0000_0013;
        if (mode == 1) return (a == jal_addr) ? 32'h0080_006F : 32'h0000_0013;
        w = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        if (w[2:0] == 3'd0) w[6:0] = 7'h6F;
        return w;
    endfunction

    // predecoder: jal target, otherwise fall-through
    function automatic logic [31:0] pred(input logic [31:0] pc, input logic [31:0] inst);
        if (inst[6:0] == 7'h6F)
            return pc + {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        return pc + 32'd4;
    endfunction

    assign bjp_pred_pc_i = pred(bjp_pc_o, bjp_inst_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check outputs against the model, advance the model.
    task automatic tick();
        logic fire, hs_out;
        reset            = rst_r;
        req_ready_i      = rdy_r;
        out_ready_i      = ordy_r;
        redirect_valid_i = redir_r;
        redirect_pc_i    = rpc_r;
        fire             = mem_busy && (mem_wait == 0);
        resp_valid_i     = fire || (!mem_busy && spur_r);
        resp_data_i      = fire ? mem_word(mem_addr) : $urandom;
        #1;
        if (model_ok) begin
            if (req_valid_o && out_valid_o) chk("excl", 32'd1, 32'd0);
            if (after_rst) begin
                chk("post_rst_req", {31'b0, req_valid_o}, 32'd0);
                chk("post_rst_out", {31'b0, out_valid_o}, 32'd0);
            end
            if (req_valid_o === 1'b1) chk("req_addr", req_addr_o, exp_pc);
            if (out_valid_o === 1'b1) begin
                chk("out_pc", out_pc_o, exp_pc);
                chk("out_inst", out_inst_o, mem_word(exp_pc));
            end
            chk("fetch_cnt", fetch_cnt_o, exp_cnt);
        end
        hs_out    = (out_valid_o === 1'b1) && ordy_r;
        after_rst = 1'b0;
        if (rst_r) begin
            exp_pc    = RPC;
            exp_cnt   = '0;
            after_rst = 1'b1;
            model_ok  = 1'b1;
            // an abandoned request's response lands while the DUT sits in IDLE
            if (fire) mem_busy = 1'b0;
            else if (mem_busy) mem_wait = 0;
        end else begin
            if (hs_out) exp_cnt = exp_cnt + 32'd1;
            if (redir_r) exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
            else if (hs_out) exp_pc = pred(exp_pc, mem_word(exp_pc)) & 32'hFFFF_FFFC;
            if (fire) mem_busy = 1'b0;
            else if (mem_busy) mem_wait--;
            if ((req_valid_o === 1'b1) && rdy_r) begin
                mem_busy = 1'b1;
                mem_addr = req_addr_o;
                mem_wait = lat_r;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // reset release and zero-wait latency
        tick(); tick();
        rst_r = 1'b0;
        chk("rst_out_inst", out_inst_o, 32'h0);
        chk("rst_out_pc", out_pc_o, 32'h0);
        tick();
        chk("c1_req_valid", {31'b0, req_valid_o}, 32'd1);
        chk("c1_req_addr", req_addr_o, 32'h8000_0000);
        tick();
        chk("c2_out_valid", {31'b0, out_valid_o}, 32'd0);
        tick();
        chk("c3_out_valid", {31'b0, out_valid_o}, 32'd1);
        chk("c3_out_pc", out_pc_o, 32'h8000_0000);
        chk("c3_out_inst", out_inst_o, 32'h0000_0013);
        tick();
        chk("c4_req_addr", req_addr_o, 32'h8000_0004);
        chk("c4_cnt", fetch_cnt_o, 32'd1);

        // jal +8 at the reset PC
        rst_r = 1'b1; tick(); rst_r = 1'b0;
        mode = 1; jal_addr = RPC;
        tick(); tick(); tick();
        chk("jal_inst", out_inst_o, 32'h0080_006F);
        tick();
        chk("jal_target", req_addr_o, 32'h8000_0008);

        // decode stalls for 5 cycles
        ordy_r = 1'b0;
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", {31'b0, out_valid_o}, 32'd1);
            chk("hold_pc", out_pc_o, 32'h8000_0008);
            chk("hold_inst", out_inst_o, 32'h0000_0013);
            chk("hold_req", {31'b0, req_valid_o}, 32'd0);
            chk("hold_cnt", fetch_cnt_o, 32'd1);
            tick();
        end
        ordy_r = 1'b1;
        tick();
        chk("hold_cnt_after", fetch_cnt_o, 32'd2);
        chk("hold_next_addr", req_addr_o, 32'h8000_000C);

        // redirect in WAIT, response two cycles later is dropped
        lat_r = 2;
        tick();
        redir_r = 1'b1; rpc_r = 32'h8000_0100;
        tick();
        redir_r = 1'b0;
        chk("drop_out0", {31'b0, out_valid_o}, 32'd0);
        tick();
        chk("drop_out1", {31'b0, out_valid_o}, 32'd0);
        tick();
        chk("drop_out2", {31'b0, out_valid_o}, 32'd0);
        chk("drop_req", {31'b0, req_valid_o}, 32'd1);
        chk("drop_addr", req_addr_o, 32'h8000_0100);

        // memory back-pressure, then a misaligned redirect
        lat_r = 0; rdy_r = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_addr", req_addr_o, 32'h8000_0100);
        end
        redir_r = 1'b1; rpc_r = 32'h8000_0203;
        tick();
        redir_r = 1'b0;
        chk("bp_redir_addr", req_addr_o, 32'h8000_0200);

        // reset while waiting, response arrives the following cycle
        rdy_r = 1'b1; lat_r = 1;
        tick();
        rst_r = 1'b1; tick(); rst_r = 1'b0;
        tick();
        chk("rstw_addr", req_addr_o, RPC);
        chk("rstw_cnt", fetch_cnt_o, 32'd0);
        chk("rstw_out", {31'b0, out_valid_o}, 32'd0);

        // randomized traffic
        mode = 2;
        begin
            logic [31:0] delivered = '0;
            for (int i = 0; i < 4000; i++) begin
                rst_r   = ($urandom_range(0, 299) == 0);
                rdy_r   = ($urandom_range(0, 3) != 0);
                ordy_r  = ($urandom_range(0, 9) < 7);
                redir_r = !after_rst && ($urandom_range(0, 11) == 0);
                rpc_r   = $urandom;
                lat_r   = $urandom_range(0, 3);
                spur_r  = ($urandom_range(0, 4) == 0);
                if ((out_valid_o === 1'b1) && ordy_r && !rst_r) delivered++;
                tick();
            end
            chk("progress", {31'b0, (delivered > 32'd200)}, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
